// File: rtl/if_stage_fetch.sv
// if_stage_fetch: MIPS IF stage owning the PC, fetching over req/ack and loading the IF/ID register
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [5:0]  ifid_opcode
);
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_KILL} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pc4, addr_n;
  logic [31:0] pend_instr, pend_instr_n, pend_pc4, pend_pc4_n;
  logic [31:0] instr_n, ifid_pc4_n;
  logic        valid_n, ack;
  assign pc4 = pc + 32'd4;
  // a response only counts while a request is actually on the bus
  assign ack = imem_ack & imem_req;
  assign ifid_opcode = ifid_instr[31:26];
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = ifid_instr;
    ifid_pc4_n = ifid_pc4;
    valid_n = ifid_valid;
    pend_instr_n = pend_instr;
    pend_pc4_n = pend_pc4;
    if (redirect) begin
      pc_n = {redirect_pc[31:2], 2'b00};
      instr_n = NOP_INSTR;
      ifid_pc4_n = 32'd0;
      valid_n = 1'b0;
      pend_instr_n = NOP_INSTR;
      pend_pc4_n = 32'd0;
      state_n = (imem_req && !ack) ? S_KILL : S_REQ;
    end else if (state == S_HOLD) begin
      if (!id_stall) begin
        instr_n = pend_instr;
        ifid_pc4_n = pend_pc4;
        valid_n = 1'b1;
        pend_instr_n = NOP_INSTR;
        pend_pc4_n = 32'd0;
        state_n = S_REQ;
      end
    end else if (state == S_REQ && ack) begin
      pc_n = pc4;
      if (id_stall) begin
        pend_instr_n = imem_rdata;
        pend_pc4_n = pc4;
        state_n = S_HOLD;
      end else begin
        instr_n = imem_rdata;
        ifid_pc4_n = pc4;
        valid_n = 1'b1;
      end
    end else begin
      state_n = (state == S_KILL && ack) ? S_REQ : state;
      if (!id_stall) begin
        instr_n = NOP_INSTR;
        ifid_pc4_n = 32'd0;
        valid_n = 1'b0;
      end
    end
    addr_n = (state_n == S_KILL) ? imem_addr : pc_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pc4 <= 32'd0;
      ifid_valid <= 1'b0;
      pend_instr <= NOP_INSTR;
      pend_pc4 <= 32'd0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      imem_req <= state_n != S_HOLD;
      imem_addr <= addr_n;
      ifid_instr <= instr_n;
      ifid_pc4 <= ifid_pc4_n;
      ifid_valid <= valid_n;
      pend_instr <= pend_instr_n;
      pend_pc4 <= pend_pc4_n;
    end
  end
endmodule

// File: tb/tb_if_stage_fetch.sv
// tb_if_stage_fetch: directed checks of the fetch stage handshake, stall, redirect and reset
module tb_if_stage_fetch;
  logic clk = 1'b0, rst = 1'b1, imem_req, imem_ack = 1'b0, id_stall = 1'b0, redirect = 1'b0, ifid_valid;
  logic [31:0] imem_addr, imem_rdata = 32'd0, redirect_pc = 32'd0, ifid_instr, ifid_pc4;
  logic [5:0] ifid_opcode;
  int passed = 0, total = 0;
  if_stage_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .ifid_opcode(ifid_opcode)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  initial begin
    step();
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_instr", ifid_instr, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h8C080004;
    step();
    chk("lw_opcode", 32'(ifid_opcode), 32'd35);
    chk("lw_pc4", ifid_pc4, 32'h4);
    chk("lw_valid", 32'(ifid_valid), 32'd1);
    chk("addr4", imem_addr, 32'h4);
    imem_rdata = 32'hAC090008;
    step();
    chk("sw_opcode", 32'(ifid_opcode), 32'd43);
    chk("sw_pc4", ifid_pc4, 32'h8);
    chk("addr8", imem_addr, 32'h8);
    imem_rdata = 32'h1109000C; id_stall = 1'b1;
    step();
    chk("stall_hold_instr", ifid_instr, 32'hAC090008);
    chk("stall_hold_pc4", ifid_pc4, 32'h8);
    chk("stall_req_low", 32'(imem_req), 32'd0);
    imem_ack = 1'b0; id_stall = 1'b0;
    step();
    chk("unstall_instr", ifid_instr, 32'h1109000C);
    chk("unstall_pc4", ifid_pc4, 32'hC);
    chk("unstall_req", 32'(imem_req), 32'd1);
    chk("unstall_addr", imem_addr, 32'hC);
    imem_ack = 1'b1; imem_rdata = 32'h20000001;
    step();
    chk("addr10", imem_addr, 32'h10);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    chk("redir_valid", 32'(ifid_valid), 32'd0);
    chk("kill_addr", imem_addr, 32'h10);
    chk("kill_req", 32'(imem_req), 32'd1);
    redirect = 1'b0;
    step();
    chk("kill_addr_hold", imem_addr, 32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    step();
    chk("kill_drop_instr", ifid_instr, 32'h0);
    chk("kill_drop_valid", 32'(ifid_valid), 32'd0);
    chk("addr40", imem_addr, 32'h40);
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFE; imem_rdata = 32'h11111111;
    step();
    chk("align_addr", imem_addr, 32'hFFFFFFFC);
    chk("redir_ack_valid", 32'(ifid_valid), 32'd0);
    redirect = 1'b0; imem_rdata = 32'h08000000;
    step();
    chk("wrap_pc4", ifid_pc4, 32'h0);
    chk("j_opcode", 32'(ifid_opcode), 32'd2);
    chk("wrap_addr", imem_addr, 32'h0);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    chk("kill2_addr", imem_addr, 32'h0);
    redirect = 1'b0; rst = 1'b1;
    step();
    chk("midrst_req", 32'(imem_req), 32'd0);
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h12345678;
    step();
    chk("late_ack_valid", 32'(ifid_valid), 32'd0);
    chk("late_ack_instr", ifid_instr, 32'h0);
    chk("late_ack_req", 32'(imem_req), 32'd1);
    chk("late_ack_addr", imem_addr, 32'h0);
    imem_ack = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
